// File: rtl/dp_pkg.sv
// Shared types and instruction-field layout for the 3-stage pipelined datapath.
// Field offsets are functions of DATA_W/RA_W so every parameterisation shares one layout.
package dp_pkg;

  typedef enum logic [1:0] {
    CLS_R    = 2'b00,
    CLS_I    = 2'b01,
    CLS_BZ   = 2'b10,
    CLS_HALT = 2'b11
  } cls_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_NOT  = 3'b101,
    ALU_SLT  = 3'b110,
    ALU_PASS = 3'b111
  } alu_op_e;

  // Flag register contents produced by the ALU alongside its result.
  typedef struct packed {
    logic zero;
    logic carry;
  } alu_flags_t;

  // Layout MSB->LSB: cls[2] op[3] rd[RA_W] rs1[RA_W] low[DATA_W]
  function automatic int instr_w(int dw, int raw);
    return dw + 2 * raw + 5;
  endfunction

  function automatic int cls_lsb(int dw, int raw);
    return dw + 2 * raw + 3;
  endfunction

  function automatic int op_lsb(int dw, int raw);
    return dw + 2 * raw;
  endfunction

  function automatic int rd_lsb(int dw, int raw);
    return dw + raw;
  endfunction

  function automatic int rs1_lsb(int dw);
    return dw;
  endfunction

endpackage

// File: rtl/pipelined_data_path_alu.sv
// Combinational parametrised ALU: result plus zero/carry; carry is carry-out on ADD,
// borrow on SUB and 0 otherwise.
module alu_param
  import dp_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              carry_o
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum      = {1'b0, a_i} + {1'b0, b_i};
    result_o = '0;
    carry_o  = 1'b0;
    unique case (op_i)
      ALU_ADD:  {carry_o, result_o} = sum;
      ALU_SUB: begin
        result_o = a_i - b_i;
        carry_o  = (a_i < b_i);
      end
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_NOT:  result_o = ~a_i;
      ALU_SLT:  result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
      ALU_PASS: result_o = b_i;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/pipelined_data_path.sv
// 3-stage (IF, EX, WB) datapath with WB->EX bypass, zero/carry flags, branch-on-zero
// with one-bubble flush, HALT, and a global freeze enable.
module pipelined_data_path
  import dp_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int RA_W    = 3,
  parameter  int PC_W    = 12,
  localparam int INSTR_W = instr_w(DATA_W, RA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               halted,
  output logic               dbg_wb_en,
  output logic [RA_W-1:0]    dbg_wb_addr,
  output logic [DATA_W-1:0]  dbg_wb_data,
  output logic               dbg_zero,
  output logic               dbg_carry
);

  localparam int CLS_LSB = cls_lsb(DATA_W, RA_W);
  localparam int OP_LSB  = op_lsb(DATA_W, RA_W);
  localparam int RD_LSB  = rd_lsb(DATA_W, RA_W);
  localparam int RS1_LSB = rs1_lsb(DATA_W);
  localparam int NREGS   = 2 ** RA_W;

  if (PC_W > DATA_W + 2 * RA_W) begin : g_pc_w_check
    $error("PC_W must not exceed DATA_W+2*RA_W");
  end

  // Pipeline state
  logic [PC_W-1:0]    pc_q,      pc_d;
  logic [INSTR_W-1:0] ir_q,      ir_d;
  logic               ir_vld_q,  ir_vld_d;
  logic               wb_vld_q,  wb_vld_d;
  logic [RA_W-1:0]    wb_rd_q,   wb_rd_d;
  logic [DATA_W-1:0]  wb_dat_q,  wb_dat_d;
  alu_flags_t         flags_q,   flags_d;
  logic               halted_q,  halted_d;
  logic [DATA_W-1:0]  rf_q [NREGS];

  // EX decode
  cls_e              ex_cls;
  alu_op_e           ex_op;
  logic [RA_W-1:0]   ex_rd, ex_rs1, ex_rs2;
  logic [DATA_W-1:0] ex_imm;
  logic [PC_W-1:0]   ex_tgt;
  logic              ex_alu_vld, ex_bz_taken, ex_halt;
  logic [DATA_W-1:0] ex_a, ex_b, rs2_val;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero, alu_carry;
  logic              wb_wr;

  assign ex_cls = cls_e'(ir_q[CLS_LSB +: 2]);
  assign ex_op  = alu_op_e'(ir_q[OP_LSB +: 3]);
  assign ex_rd  = ir_q[RD_LSB +: RA_W];
  assign ex_rs1 = ir_q[RS1_LSB +: RA_W];
  assign ex_rs2 = ir_q[DATA_W-1 -: RA_W];
  assign ex_imm = ir_q[DATA_W-1:0];
  assign ex_tgt = ir_q[PC_W-1:0];

  assign ex_alu_vld  = ir_vld_q && (ex_cls == CLS_R || ex_cls == CLS_I);
  assign ex_bz_taken = ir_vld_q && (ex_cls == CLS_BZ) && flags_q.zero;
  assign ex_halt     = ir_vld_q && (ex_cls == CLS_HALT);

  // A register writing back this cycle is not yet in rf_q, so it is forwarded.
  assign wb_wr = wb_vld_q && (wb_rd_q != '0);

  always_comb begin
    ex_a = '0;
    if (ex_rs1 != '0) begin
      ex_a = (wb_wr && wb_rd_q == ex_rs1) ? wb_dat_q : rf_q[ex_rs1];
    end
    rs2_val = '0;
    if (ex_rs2 != '0) begin
      rs2_val = (wb_wr && wb_rd_q == ex_rs2) ? wb_dat_q : rf_q[ex_rs2];
    end
    ex_b = (ex_cls == CLS_R) ? rs2_val : ex_imm;
  end

  alu_param #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i      (ex_a),
    .b_i      (ex_b),
    .op_i     (ex_op),
    .result_o (alu_res),
    .zero_o   (alu_zero),
    .carry_o  (alu_carry)
  );

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    ir_vld_d = ir_vld_q;
    wb_vld_d = wb_vld_q;
    wb_rd_d  = wb_rd_q;
    wb_dat_d = wb_dat_q;
    flags_d  = flags_q;
    halted_d = halted_q;
    if (en) begin
      wb_vld_d = ex_alu_vld;
      wb_rd_d  = ex_rd;
      wb_dat_d = alu_res;
      if (ex_alu_vld) begin
        flags_d.zero  = alu_zero;
        flags_d.carry = alu_carry;
      end
      // pc already points past HALT when it reaches EX, so holding pc parks it there.
      if (halted_q || ex_halt) begin
        halted_d = 1'b1;
        ir_vld_d = 1'b0;
      end else if (ex_bz_taken) begin
        pc_d     = ex_tgt;
        ir_vld_d = 1'b0;
      end else begin
        ir_d     = imem_data;
        ir_vld_d = 1'b1;
        pc_d     = pc_q + PC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      ir_q     <= '0;
      ir_vld_q <= 1'b0;
      wb_vld_q <= 1'b0;
      wb_rd_q  <= '0;
      wb_dat_q <= '0;
      flags_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ir_vld_q <= ir_vld_d;
      wb_vld_q <= wb_vld_d;
      wb_rd_q  <= wb_rd_d;
      wb_dat_q <= wb_dat_d;
      flags_q  <= flags_d;
      halted_q <= halted_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (en && wb_wr) begin
      rf_q[wb_rd_q] <= wb_dat_q;
    end
  end

  assign imem_addr   = pc_q;
  assign halted      = halted_q;
  assign dbg_wb_en   = en && wb_wr;
  assign dbg_wb_addr = wb_rd_q;
  assign dbg_wb_data = wb_dat_q;
  assign dbg_zero    = flags_q.zero;
  assign dbg_carry   = flags_q.carry;

endmodule
